// File: rtl/sigmoid_inverse.sv
// Inverse sigmoid: finds the largest Q3.4 x with S(x) <= p, one result bit per clock.
// Optional exact-match flag port out_exact is built only when SIGINV_EXACT_EN is defined.
module sigmoid_inverse (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_p,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_x
`ifdef SIGINV_EXACT_EN
  ,
  output logic       out_exact
`endif
);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t     state, state_nxt;
  logic [7:0] cur, cur_nxt, trial, p_q;
  logic [2:0] k;
  logic       keep, last_bit;

  // Piecewise-linear sigmoid on a signed Q3.4 input, result in unsigned Q0.8.
  function automatic logic [7:0] sig(input logic [7:0] x);
    logic [7:0] a;
    logic [8:0] ypos;
    a = x[7] ? (8'd0 - x) : x;
    if (a >= 8'd80)      ypos = 9'd256;
    else if (a >= 8'd38) ypos = {2'b00, a[7:1]} + 9'd216;
    else if (a >= 8'd16) ypos = {a, 1'b0} + 9'd160;
    else                 ypos = {a[6:0], 2'b00} + 9'd128;
    if (x[7]) sig = 8'(9'd256 - ypos);
    else      sig = ypos[8] ? 8'hFF : ypos[7:0];
  endfunction

  // Search runs on offset binary u = x + 128 so S is monotone in u.
  always_comb begin
    trial    = cur | (8'd1 << k);
    keep     = (sig(trial ^ 8'h80) <= p_q);
    cur_nxt  = keep ? trial : cur;
    last_bit = (k == 3'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = SEARCH;
      end
      SEARCH: begin
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur   <= 8'h00;
      k     <= 3'd0;
      p_q   <= 8'h00;
      out_x <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            p_q <= in_p;
            cur <= 8'h00;
            k   <= 3'd7;
          end
        end
        SEARCH: begin
          cur <= cur_nxt;
          k   <= k - 3'd1;
          if (last_bit) out_x <= cur_nxt ^ 8'h80;
        end
        default: ;
      endcase
    end
  end

`ifdef SIGINV_EXACT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      out_exact <= 1'b0;
    else if (state == SEARCH && last_bit)
      out_exact <= (sig(cur_nxt ^ 8'h80) == p_q);
    else if (state == DONE && out_ready)
      out_exact <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_sigmoid_inverse.sv
// Directed bench for sigmoid_inverse; checks out_exact as well when SIGINV_EXACT_EN is defined.
module tb_sigmoid_inverse;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_p;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_x;
`ifdef SIGINV_EXACT_EN
  logic       out_exact;
`endif

  int checks   = 0;
  int failures = 0;
  int n;
  logic seen;

  sigmoid_inverse dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_p      (in_p),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x)
`ifdef SIGINV_EXACT_EN
    ,
    .out_exact (out_exact)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_exact(input string tag, input logic exp);
`ifdef SIGINV_EXACT_EN
    check(tag, {31'b0, out_exact}, {31'b0, exp});
`else
    if (exp === 1'bz) tick();
`endif
  endtask

  task automatic accept(input string tag, input logic [7:0] p);
    check({tag, "_rdy"}, {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_p     = p;
    tick();
    in_valid = 1'b0;
    in_p     = ~p;
    check({tag, "_busy"}, {31'b0, in_ready}, 32'd0);
  endtask

  task automatic wait_out(input string tag, input logic [7:0] ex, input logic ee, input int lat);
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, n, lat);
    check({tag, "_x"}, {24'b0, out_x}, {24'b0, ex});
    check_exact({tag, "_exact"}, ee);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_hs_vld"}, {31'b0, out_valid}, 32'd0);
    check({tag, "_hs_rdy"}, {31'b0, in_ready}, 32'd1);
  endtask

  task automatic run(input string tag, input logic [7:0] p, input logic [7:0] ex, input logic ee);
    accept(tag, p);
    wait_out(tag, ex, ee, 8);
    handshake(tag);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_p      = 8'h00;
    out_ready = 1'b0;
    tick();
    tick();
    check("rst_vld", {31'b0, out_valid}, 32'd0);
    check("rst_x", {24'b0, out_x}, 32'h00);
    check_exact("rst_exact", 1'b0);
    rst_n = 1'b1;
    check("rst_rdy", {31'b0, in_ready}, 32'd1);

    // first request right on the first edge after reset release
    run("p80", 8'h80, 8'h00, 1'b1);
    run("pff", 8'hFF, 8'h7F, 1'b1);
    run("p00", 8'h00, 8'hB0, 1'b1);
    run("pc8", 8'hC8, 8'h14, 1'b1);
    run("p64", 8'h64, 8'hF9, 1'b1);
    run("p81", 8'h81, 8'h00, 1'b0);

    // output stall with a competing request held on the input
    accept("stall", 8'hC8);
    wait_out("stall", 8'h14, 1'b1, 8);
    in_valid = 1'b1;
    in_p     = 8'h64;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_vld", {31'b0, out_valid}, 32'd1);
      check("stall_x", {24'b0, out_x}, 32'h14);
      check("stall_rdy", {31'b0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    handshake("stall");
    check("stall_hold_x", {24'b0, out_x}, 32'h14);
    run("second", 8'h64, 8'hF9, 1'b1);

    // reset in the middle of a search
    accept("rstmid", 8'hC8);
    repeat (3) tick();
    rst_n = 1'b0;
    #2;
    check("rstmid_vld", {31'b0, out_valid}, 32'd0);
    check("rstmid_rdy", {31'b0, in_ready}, 32'd1);
    check("rstmid_x", {24'b0, out_x}, 32'h00);
    check_exact("rstmid_exact", 1'b0);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid === 1'b1) seen = 1'b1;
    end
    check("rstmid_no_out", {31'b0, seen}, 32'd0);
    run("after_rst", 8'h80, 8'h00, 1'b1);

    // input changes, a stray in_valid and out_ready during search are ignored
    accept("ign", 8'h80);
    tick();
    tick();
    in_p      = 8'hFF;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    wait_out("ign", 8'h00, 1'b1, 5);
    handshake("ign");
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid === 1'b1) seen = 1'b1;
    end
    check("ign_no_extra", {31'b0, seen}, 32'd0);
    check("ign_idle_rdy", {31'b0, in_ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
